// File: rtl/conv_0_pkg.sv
// Shared constants and types for the conv_0 window accumulator.
// Holds the product/output widths, the output clamp range and the
// accumulator flow-control state type.
package conv_0_pkg;

    localparam int unsigned PROD_WIDTH = 24;
    localparam int unsigned OUT_WIDTH  = 16;
    localparam int unsigned CNT_WIDTH  = 8;
    localparam int          OUT_MAX    = 32767;
    localparam int          OUT_MIN    = -32768;

    // ST_ACC: window filling, or last tap with the output free.
    // ST_STALL: last tap pending while the output register is occupied.
    typedef enum logic [0:0] {
        ST_ACC   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/conv_0_acc_requant.sv
// Combinational requantizer: round-half-up, arithmetic right shift, then
// clamp (CONV_0_ACC_SAT_EN defined) or truncate to OUT_WIDTH bits.
// Ports:
//   acc_i   - signed window sum
//   res_o_c - requantized result (combinational)
//   sat_o_c - result was clamped (combinational, 0 without CONV_0_ACC_SAT_EN)
module conv_0_acc_requant
    import conv_0_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned SHIFT     = 8
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    output logic        [OUT_WIDTH-1:0] res_o_c,
    output logic                        sat_o_c
);

    // One guard bit so adding the rounding constant cannot wrap.
    localparam int unsigned RW = ACC_WIDTH + 1;
    localparam logic signed [RW-1:0] RND = RW'((64'd1 << SHIFT) >> 1);

    logic signed [RW-1:0] sum_c;
    logic signed [RW-1:0] shr_c;

    assign sum_c = RW'(acc_i) + RND;
    assign shr_c = sum_c >>> SHIFT;

`ifdef CONV_0_ACC_SAT_EN
    localparam logic signed [RW-1:0] MAX_W = RW'(OUT_MAX);
    localparam logic signed [RW-1:0] MIN_W = RW'(OUT_MIN);

    // Clamp to the signed output range.
    always_comb begin
        res_o_c = OUT_WIDTH'(shr_c);
        sat_o_c = 1'b0;
        if (shr_c > MAX_W) begin
            res_o_c = OUT_WIDTH'(MAX_W);
            sat_o_c = 1'b1;
        end else if (shr_c < MIN_W) begin
            res_o_c = OUT_WIDTH'(MIN_W);
            sat_o_c = 1'b1;
        end
    end
`else
    // Plain truncation to the low output bits.
    assign res_o_c = OUT_WIDTH'(shr_c);
    assign sat_o_c = 1'b0;
`endif

endmodule

// File: rtl/conv_0_acc_window.sv
// Convolution window accumulator: sums KSIZE signed products, requantizes
// the window sum and presents it on a valid/ready output register.
// Optional feature macro: CONV_0_ACC_SAT_EN (clamp result, drive sat_hit).
// Ports:
//   ap_clk, ap_rst_n        - clock, async active-low reset
//   prod_data/valid/ready   - product input handshake (prod_ready is combinational)
//   clear                   - discard the partial window
//   out_data/valid, out_ready - result output handshake
//   sat_hit                 - pulse when a loaded result was clamped
//   tap_cnt                 - products accepted in the current window
module conv_0_acc_window
    import conv_0_pkg::*;
#(
    parameter int unsigned KSIZE     = 9,
    parameter int unsigned SHIFT     = 8,
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    input  logic                  clear,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_hit,
    output logic [CNT_WIDTH-1:0]  tap_cnt
);

    localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(KSIZE - 1);

    // Parameter legality checks at elaboration.
    if (ACC_WIDTH < PROD_WIDTH + $clog2(KSIZE)) begin : g_acc_width_chk
        $error("conv_0_acc_window: ACC_WIDTH too small for KSIZE");
    end
    if (KSIZE < 1 || KSIZE > 256) begin : g_ksize_chk
        $error("conv_0_acc_window: KSIZE out of range 1..256");
    end
    if (SHIFT > 15) begin : g_shift_chk
        $error("conv_0_acc_window: SHIFT out of range 0..15");
    end

    state_e                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]         tap_q, tap_d;
    logic [OUT_WIDTH-1:0]         out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic                         sat_q, sat_d;

    logic                         accept_c;
    logic                         done_c;
    logic signed [ACC_WIDTH-1:0]  base_acc_c;
    logic [CNT_WIDTH-1:0]         base_tap_c;
    logic signed [ACC_WIDTH-1:0]  sum_c;
    logic [OUT_WIDTH-1:0]         rq_res_c;
    logic                         rq_sat_c;

    conv_0_acc_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT)
    ) u_requant (
        .acc_i   (sum_c),
        .res_o_c (rq_res_c),
        .sat_o_c (rq_sat_c)
    );

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: stalled whenever the last tap is pending behind a held result.
    always_comb begin
        state_d = ST_ACC;
        if ((tap_d == LAST_TAP) && out_valid_d) begin
            state_d = ST_STALL;
        end
    end

    // Flow-control output: only the window-completing product can be blocked.
    always_comb begin
        prod_ready = 1'b1;
        if ((state_q == ST_STALL) && !out_ready) begin
            prod_ready = 1'b0;
        end
    end

    // Datapath next values; clear rebases the window before the product adds in.
    always_comb begin
        accept_c    = prod_valid && prod_ready;
        base_acc_c  = clear ? '0 : acc_q;
        base_tap_c  = clear ? '0 : tap_q;
        sum_c       = base_acc_c + ACC_WIDTH'($signed(prod_data));
        done_c      = accept_c && (base_tap_c == LAST_TAP);

        acc_d       = base_acc_c;
        tap_d       = base_tap_c;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sat_d       = 1'b0;

        if (done_c) begin
            acc_d       = '0;
            tap_d       = '0;
            out_data_d  = rq_res_c;
            out_valid_d = 1'b1;
            sat_d       = rq_sat_c;
        end else begin
            if (accept_c) begin
                acc_d = sum_c;
                tap_d = base_tap_c + CNT_WIDTH'(1);
            end
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            tap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sat_hit   = sat_q;
    assign tap_cnt   = tap_q;

endmodule
